// File: rtl/wb_target_tag_mem_pkg.sv
// Shared definitions for the tagged Wishbone target memory.
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - wait-state counter width
//   - lsb_of(): byte-offset bit count for a given data width
package wb_target_tag_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int WCNT_WIDTH = 4;

    // Number of address bits that select a byte within one data word.
    function automatic int lsb_of(input int dat_width);
        return $clog2(dat_width / 8);
    endfunction

endpackage

// File: rtl/wb_target_tag_mem_if.sv
// Wishbone classic bus with address, cycle and data tags.
//   master modport: drives request (adr, dat_w, cyc, stb, we, sel, tgd_w, tga, tgc)
//   slave  modport: drives response (dat_r, tgd_r, ack, err)
interface wb_target_tag_mem_if #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int TGA_WIDTH = 4,
    parameter int TGC_WIDTH = 4,
    parameter int TGD_WIDTH = 4
);
    logic [ADR_WIDTH-1:0]   adr;
    logic [DAT_WIDTH-1:0]   dat_w;
    logic [DAT_WIDTH-1:0]   dat_r;
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [DAT_WIDTH/8-1:0] sel;
    logic                   ack;
    logic                   err;
    logic [TGD_WIDTH-1:0]   tgd_w;
    logic [TGD_WIDTH-1:0]   tgd_r;
    logic [TGA_WIDTH-1:0]   tga;
    logic [TGC_WIDTH-1:0]   tgc;

    modport master (
        output adr, dat_w, cyc, stb, we, sel, tgd_w, tga, tgc,
        input  dat_r, ack, err, tgd_r
    );

    modport slave (
        input  adr, dat_w, cyc, stb, we, sel, tgd_w, tga, tgc,
        output dat_r, ack, err, tgd_r
    );
endinterface

// File: rtl/wb_target_tag_ram.sv
// Word memory with a per-word data tag.
//   clk_i  : clock
//   we_i   : write strobe (qualified by sel_i per byte)
//   sel_i  : byte enables; the tag is written when any byte is enabled
//   idx_i  : word index, shared by write and combinational read
//   wdat_i / wtag_i : write data and tag
//   rdat_o / rtag_o : combinational read of word idx_i
module wb_target_tag_ram #(
    parameter int DAT_WIDTH      = 32,
    parameter int TGD_WIDTH      = 4,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [DAT_WIDTH/8-1:0]    sel_i,
    input  logic [MEM_DEPTH_LOG2-1:0] idx_i,
    input  logic [DAT_WIDTH-1:0]      wdat_i,
    input  logic [TGD_WIDTH-1:0]      wtag_i,
    output logic [DAT_WIDTH-1:0]      rdat_o,
    output logic [TGD_WIDTH-1:0]      rtag_o
);
    localparam int NBYTES = DAT_WIDTH / 8;
    localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;

    logic [DAT_WIDTH-1:0] dat_mem_q [DEPTH];
    logic [TGD_WIDTH-1:0] tag_mem_q [DEPTH];

    // NOTE: storage arrays have no reset; contents survive rst_ni so they map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (sel_i[b]) dat_mem_q[idx_i][8*b +: 8] <= wdat_i[8*b +: 8];
            end
            if (|sel_i) tag_mem_q[idx_i] <= wtag_i;
        end
    end

    assign rdat_o = dat_mem_q[idx_i];
    assign rtag_o = tag_mem_q[idx_i];
endmodule

// File: rtl/wb_target_tag_mem.sv
// Wishbone classic target backed by a tagged word memory.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : slave side of the tagged Wishbone bus
//   last_tga_o    : tga of the most recent acked access
//   last_tgc_o    : tgc of the most recent acked access
//   xfer_count_o  : number of acked accesses (wraps at 16 bits)
// A request is latched in IDLE, waits WAIT_STATES cycles, then answers with a
// single-cycle ack or err. Dropping cyc while waiting aborts the access.
module wb_target_tag_mem
    import wb_target_tag_mem_pkg::*;
#(
    parameter int ADR_WIDTH      = 32,
    parameter int DAT_WIDTH      = 32,
    parameter int TGA_WIDTH      = 4,
    parameter int TGC_WIDTH      = 4,
    parameter int TGD_WIDTH      = 4,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int WAIT_STATES    = 1,
    parameter logic [ADR_WIDTH-1:0] RANGE_MASK = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    wb_target_tag_mem_if.slave   bus,
    output logic [TGA_WIDTH-1:0] last_tga_o,
    output logic [TGC_WIDTH-1:0] last_tgc_o,
    output logic [15:0]          xfer_count_o
);
    localparam int LSB = lsb_of(DAT_WIDTH);
    localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ADR_WIDTH'((64'd1 << LSB) - 64'd1);

    logic [1:0]                state_q, state_d;
    logic [WCNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                      we_q, we_d;
    logic                      fault_q, fault_d;
    logic [DAT_WIDTH/8-1:0]    sel_q, sel_d;
    logic [DAT_WIDTH-1:0]      wdat_q, wdat_d;
    logic [TGD_WIDTH-1:0]      wtag_q, wtag_d;
    logic [TGA_WIDTH-1:0]      tga_q, tga_d, last_tga_q, last_tga_d;
    logic [TGC_WIDTH-1:0]      tgc_q, tgc_d, last_tgc_q, last_tgc_d;
    logic                      ack_q, ack_d, err_q, err_d;
    logic [DAT_WIDTH-1:0]      dat_r_q, dat_r_d, ram_rdat;
    logic [TGD_WIDTH-1:0]      tgd_r_q, tgd_r_d, ram_rtag;
    logic [15:0]               xfer_count_q, xfer_count_d;
    logic                      enter_resp;

    // Request capture and sequencing. The _d copies of the latched request are
    // what the RAM and response logic use, so a zero-wait access entering RESP
    // straight from IDLE sees the request being accepted on the same edge.
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        we_d       = we_q;
        fault_d    = fault_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        wtag_d     = wtag_q;
        tga_d      = tga_q;
        tgc_d      = tgc_q;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cyc && bus.stb) begin
                    idx_d   = bus.adr[LSB +: MEM_DEPTH_LOG2];
                    we_d    = bus.we;
                    fault_d = |(bus.adr & RANGE_MASK) || |(bus.adr & ALIGN_MASK);
                    sel_d   = bus.sel;
                    wdat_d  = bus.dat_w;
                    wtag_d  = bus.tgd_w;
                    tga_d   = bus.tga;
                    tgc_d   = bus.tgc;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WCNT_WIDTH'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.cyc) begin
                    state_d = ST_IDLE;   // master abandoned the cycle
                end else if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - WCNT_WIDTH'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response registers, debug tags and the access counter.
    always_comb begin
        ack_d        = enter_resp & ~fault_d;
        err_d        = enter_resp & fault_d;
        dat_r_d      = dat_r_q;
        tgd_r_d      = tgd_r_q;
        last_tga_d   = last_tga_q;
        last_tgc_d   = last_tgc_q;
        xfer_count_d = xfer_count_q;
        if (err_d) begin
            dat_r_d = '0;
            tgd_r_d = '0;
        end else if (ack_d) begin
            if (we_d) begin
                tgd_r_d = wtag_d;
            end else begin
                dat_r_d = ram_rdat;
                tgd_r_d = ram_rtag;
            end
            last_tga_d   = tga_d;
            last_tgc_d   = tgc_d;
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            fault_q      <= 1'b0;
            sel_q        <= '0;
            wdat_q       <= '0;
            wtag_q       <= '0;
            tga_q        <= '0;
            tgc_q        <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_r_q      <= '0;
            tgd_r_q      <= '0;
            last_tga_q   <= '0;
            last_tgc_q   <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            fault_q      <= fault_d;
            sel_q        <= sel_d;
            wdat_q       <= wdat_d;
            wtag_q       <= wtag_d;
            tga_q        <= tga_d;
            tgc_q        <= tgc_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            dat_r_q      <= dat_r_d;
            tgd_r_q      <= tgd_r_d;
            last_tga_q   <= last_tga_d;
            last_tgc_q   <= last_tgc_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    // The memory itself has no reset, so the write strobe is gated by rst_ni
    // to guarantee that no word changes while reset is held.
    wb_target_tag_ram #(
        .DAT_WIDTH      (DAT_WIDTH),
        .TGD_WIDTH      (TGD_WIDTH),
        .MEM_DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (enter_resp & we_d & ~fault_d & rst_ni),
        .sel_i  (sel_d),
        .idx_i  (idx_d),
        .wdat_i (wdat_d),
        .wtag_i (wtag_d),
        .rdat_o (ram_rdat),
        .rtag_o (ram_rtag)
    );

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.dat_r    = dat_r_q;
    assign bus.tgd_r    = tgd_r_q;
    assign last_tga_o   = last_tga_q;
    assign last_tgc_o   = last_tgc_q;
    assign xfer_count_o = xfer_count_q;
endmodule

// File: tb/tb_wb_target_tag_mem.sv
// Bench for wb_target_tag_mem. Two instances: dut_a with one wait state and
// dut_b with three, both rejecting addresses with any of bits 31:28 set.
module tb_wb_target_tag_mem;
    localparam logic [31:0] MASK = 32'hF000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_target_tag_mem_if bus_a ();
    wb_target_tag_mem_if bus_b ();

    // Shared request lines; use_b steers cyc/stb to one instance.
    logic        use_b = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_w = '0;
    logic [3:0]  sel = '0, tgd_w = '0, tga = '0, tgc = '0;

    assign bus_a.cyc = cyc & ~use_b;  assign bus_b.cyc = cyc & use_b;
    assign bus_a.stb = stb & ~use_b;  assign bus_b.stb = stb & use_b;
    assign bus_a.we = we;       assign bus_b.we = we;
    assign bus_a.adr = adr;     assign bus_b.adr = adr;
    assign bus_a.dat_w = dat_w; assign bus_b.dat_w = dat_w;
    assign bus_a.sel = sel;     assign bus_b.sel = sel;
    assign bus_a.tgd_w = tgd_w; assign bus_b.tgd_w = tgd_w;
    assign bus_a.tga = tga;     assign bus_b.tga = tga;
    assign bus_a.tgc = tgc;     assign bus_b.tgc = tgc;

    logic [3:0]  lta_a, ltc_a, lta_b, ltc_b;
    logic [15:0] cnt_a, cnt_b;

    wb_target_tag_mem #(.WAIT_STATES(1), .RANGE_MASK(MASK)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a),
        .last_tga_o(lta_a), .last_tgc_o(ltc_a), .xfer_count_o(cnt_a)
    );
    wb_target_tag_mem #(.WAIT_STATES(3), .RANGE_MASK(MASK)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b),
        .last_tga_o(lta_b), .last_tgc_o(ltc_b), .xfer_count_o(cnt_b)
    );

    logic        ack_s, err_s;
    logic [31:0] dat_s;
    logic [3:0]  tgd_s, lta_s, ltc_s;
    logic [15:0] cnt_s;
    assign ack_s = use_b ? bus_b.ack   : bus_a.ack;
    assign err_s = use_b ? bus_b.err   : bus_a.err;
    assign dat_s = use_b ? bus_b.dat_r : bus_a.dat_r;
    assign tgd_s = use_b ? bus_b.tgd_r : bus_a.tgd_r;
    assign lta_s = use_b ? lta_b : lta_a;
    assign ltc_s = use_b ? ltc_b : ltc_a;
    assign cnt_s = use_b ? cnt_b : cnt_a;

    int n_checks = 0;
    int n_fail   = 0;

    // One observed (or predicted) transaction: latency in cycles after the
    // accept edge, the response cycle, and the cycle that follows it.
    typedef struct packed {
        logic [7:0]  lat;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic [3:0]  tgd;
        logic [15:0] cnt;
        logic [3:0]  lta;
        logic [3:0]  ltc;
        logic        ack_nx;
        logic        err_nx;
        logic [31:0] dat_nx;
        logic [3:0]  tgd_nx;
    } resp_t;

    // Reference model: per-instance word store keyed by (instance, word index).
    logic [31:0] m_dat [int];
    logic [3:0]  m_tag [int];
    logic [31:0] e_dat_r [2];
    logic [3:0]  e_tgd_r [2];
    logic [3:0]  e_tga [2];
    logic [3:0]  e_tgc [2];
    logic [15:0] e_cnt [2];
    int          ws [2] = '{1, 3};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_dat_r[k] = '0; e_tgd_r[k] = '0; e_tga[k] = '0; e_tgc[k] = '0; e_cnt[k] = '0;
        end
    endtask

    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] tg, input logic [3:0] ta,
                         input logic [3:0] tc, output resp_t e);
        int          k   = use_b ? 1 : 0;
        int          key = k * 1024 + int'(a[11:2]);
        bit          bad = ((a & MASK) != 0) || (a[1:0] != 2'b00);
        logic [31:0] word;
        if (bad) begin
            e_dat_r[k] = '0;
            e_tgd_r[k] = '0;
        end else begin
            if (w) begin
                word = m_dat.exists(key) ? m_dat[key] : 'x;
                for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
                if (s != 0) begin
                    m_dat[key] = word;
                    m_tag[key] = tg;
                end
                e_tgd_r[k] = tg;
            end else begin
                e_dat_r[k] = m_dat.exists(key) ? m_dat[key] : 'x;
                e_tgd_r[k] = m_tag.exists(key) ? m_tag[key] : 'x;
            end
            e_cnt[k] = e_cnt[k] + 16'd1;
            e_tga[k] = ta;
            e_tgc[k] = tc;
        end
        e.lat    = 8'(1 + ws[k]);
        e.ack    = !bad;
        e.err    = bad;
        e.dat    = e_dat_r[k];
        e.tgd    = e_tgd_r[k];
        e.cnt    = e_cnt[k];
        e.lta    = e_tga[k];
        e.ltc    = e_tgc[k];
        e.ack_nx = 1'b0;
        e.err_nx = 1'b0;
        e.dat_nx = e_dat_r[k];
        e.tgd_nx = e_tgd_r[k];
    endtask

    // Drives one request, scrambles the request lines after the accept edge
    // and records the response. A missing response shows up as lat=32, ack=0.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [3:0] tg, input logic [3:0] ta,
                          input logic [3:0] tc, output resp_t o);
        int n   = 0;
        bit got = 1'b0;
        o = '0;
        @(negedge clk);
        we = w; adr = a; dat_w = d; sel = s; tgd_w = tg; tga = ta; tgc = tc;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        while (!got && n < 32) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                we = ~w; adr = $urandom; dat_w = $urandom;
                sel = 4'($urandom); tgd_w = 4'($urandom); tga = 4'($urandom); tgc = 4'($urandom);
            end
            got = ack_s | err_s;
        end
        o.lat = 8'(n); o.ack = ack_s; o.err = err_s; o.dat = dat_s; o.tgd = tgd_s;
        o.cnt = cnt_s; o.lta = lta_s; o.ltc = ltc_s;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        o.ack_nx = ack_s; o.err_nx = err_s; o.dat_nx = dat_s; o.tgd_nx = tgd_s;
    endtask

    // Model prediction followed by the bus transaction.
    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] tg, input logic [3:0] ta,
                        input logic [3:0] tc, output resp_t o, output resp_t e);
        model(w, a, d, s, tg, ta, tc, e);
        access(w, a, d, s, tg, ta, tc, o);
    endtask

    task automatic test_reset();
        logic [123:0] v;
        bit           seen = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        v = {bus_a.ack, bus_a.err, bus_a.dat_r, bus_a.tgd_r, lta_a, ltc_a, cnt_a,
             bus_b.ack, bus_b.err, bus_b.dat_r, bus_b.tgd_r, lta_b, ltc_b, cnt_b};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", v);
        end
        repeat (4) begin
            @(negedge clk);
            seen |= bus_a.ack | bus_a.err | bus_b.ack | bus_b.err;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got response=%0b want 0", seen);
        end
    endtask

    task automatic test_write_read();
        resp_t o, e;
        use_b = 1'b0;
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 4'h5, 4'h1, 4'h2, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL full_write: got %p want %p", o, e); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, 4'h0, 4'h3, 4'h4, o, e);
        n_checks++;
        if (o !== e || o.dat !== 32'hDEAD_BEEF || o.tgd !== 4'h5 || o.cnt !== 16'd2) begin
            n_fail++; $display("FAIL full_read: got %p want %p", o, e);
        end
    endtask

    task automatic test_byte_lane();
        resp_t o, e;
        use_b = 1'b0;
        xact(1'b1, 32'h14, 32'h1122_3344, 4'hF, 4'h1, 4'h0, 4'h0, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL lane_fill: got %p want %p", o, e); end
        xact(1'b1, 32'h14, 32'h0000_00AA, 4'b0001, 4'h2, 4'h6, 4'h7, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL lane_write: got %p want %p", o, e); end
        xact(1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0000, 4'h9, 4'h8, 4'h9, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL lane_sel0: got %p want %p", o, e); end
        xact(1'b0, 32'h14, 32'h0, 4'h0, 4'h0, 4'hA, 4'hB, o, e);
        n_checks++;
        if (o !== e || o.dat !== 32'h1122_33AA) begin
            n_fail++; $display("FAIL lane_read: got %p want %p", o, e);
        end
    endtask

    task automatic test_errors();
        resp_t o, e;
        use_b = 1'b0;
        xact(1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'hF, 4'hE, 4'hC, 4'hD, o, e);
        n_checks++;
        if (o !== e || o.err !== 1'b1) begin n_fail++; $display("FAIL err_range: got %p want %p", o, e); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, 4'h0, 4'h1, 4'h1, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL err_range_readback: got %p want %p", o, e); end
        xact(1'b1, 32'h12, 32'h0BAD_0BAD, 4'hF, 4'hE, 4'h2, 4'h2, o, e);
        n_checks++;
        if (o !== e || o.err !== 1'b1) begin n_fail++; $display("FAIL err_misaligned: got %p want %p", o, e); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, 4'h0, 4'h3, 4'h3, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL err_misaligned_readback: got %p want %p", o, e); end
    endtask

    // Second request is presented during the first one's RESP cycle with stb
    // kept high; it must be taken only in the following IDLE cycle.
    task automatic test_back_to_back();
        resp_t       e1, e2;
        int          c1 = 0, c2 = 0;
        logic [31:0] d1 = '0, d2 = '0;
        logic [3:0]  t2 = '0;
        use_b = 1'b0;
        model(1'b1, 32'h300, 32'hA5A5_0F0F, 4'hF, 4'h9, 4'h1, 4'h2, e1);
        model(1'b0, 32'h300, 32'h0, 4'h0, 4'h0, 4'h3, 4'h4, e2);
        @(negedge clk);
        we = 1'b1; adr = 32'h300; dat_w = 32'hA5A5_0F0F; sel = 4'hF; tgd_w = 4'h9; tga = 4'h1; tgc = 4'h2;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        while (c1 < 32) begin
            @(negedge clk); c1++;
            if (ack_s) break;
        end
        d1 = dat_s;
        we = 1'b0; tga = 4'h3; tgc = 4'h4;
        while (c2 < 32) begin
            @(negedge clk); c2++;
            if (ack_s) break;
        end
        d2 = dat_s; t2 = tgd_s;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({c1, c2, d1, d2, t2, cnt_s, lta_s, ltc_s} !== {32'(1 + ws[0]), 32'(2 + ws[0]), e1.dat, e2.dat, e2.tgd, e2.cnt, e2.lta, e2.ltc}) begin
            n_fail++;
            $display("FAIL back_to_back: got c1=%0d c2=%0d d1=%h d2=%h t=%h cnt=%h want c1=%0d c2=%0d d1=%h d2=%h t=%h cnt=%h",
                     c1, c2, d1, d2, t2, cnt_s, 1 + ws[0], 2 + ws[0], e1.dat, e2.dat, e2.tgd, e2.cnt);
        end
    endtask

    task automatic test_abort();
        resp_t o, e;
        bit    seen = 1'b0;
        use_b = 1'b1;
        xact(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 4'h3, 4'h5, 4'h6, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL abort_fill: got %p want %p", o, e); end
        @(negedge clk);
        we = 1'b1; adr = 32'h40; dat_w = 32'h1234_5678; sel = 4'hF; tgd_w = 4'hC; tga = 4'hF; tgc = 4'hF;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= ack_s | err_s;
        end
        n_checks++;
        if (seen !== 1'b0 || cnt_s !== e_cnt[1]) begin
            n_fail++; $display("FAIL abort_silent: got response=%0b cnt=%h want 0 cnt=%h", seen, cnt_s, e_cnt[1]);
        end
        xact(1'b0, 32'h40, 32'h0, 4'h0, 4'h0, 4'h7, 4'h8, o, e);
        n_checks++;
        if (o !== e || o.dat !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL abort_readback: got %p want %p", o, e); end
    endtask

    task automatic test_random();
        resp_t       o, e;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            use_b = (k == 1);
            for (int i = 0; i < 8; i++) begin
                xact(1'b1, 32'h200 + 32'(4 * i), $urandom, 4'hF, 4'($urandom), 4'($urandom), 4'($urandom), o, e);
                n_checks++;
                if (o !== e) begin n_fail++; $display("FAIL rand_fill[%0d.%0d]: got %p want %p", k, i, o, e); end
            end
            for (int i = 0; i < 30; i++) begin
                a = 32'h200 + 32'(4 * $urandom_range(0, 7));
                case ($urandom_range(0, 7))
                    0: a = a | 32'(2'($urandom_range(1, 3)));
                    1: a = a | {4'($urandom_range(1, 15)), 28'h0};
                    default: ;
                endcase
                xact(1'($urandom), a, $urandom, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), o, e);
                n_checks++;
                if (o !== e) begin n_fail++; $display("FAIL rand_op[%0d.%0d] adr=%h: got %p want %p", k, i, a, o, e); end
            end
        end
    endtask

    // The counter is preset just below the wrap point, then two real acks
    // carry it through 16'hFFFF to zero.
    task automatic test_wrap();
        resp_t o, e;
        use_b = 1'b0;
        @(negedge clk);
        force dut_a.xfer_count_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut_a.xfer_count_q;
        e_cnt[0] = 16'hFFFE;
        xact(1'b0, 32'h10, 32'h0, 4'h0, 4'h0, 4'h4, 4'h5, o, e);
        n_checks++;
        if (o !== e || o.cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %p want %p", o, e); end
        xact(1'b1, 32'h18, 32'h0102_0304, 4'hF, 4'h6, 4'hA, 4'h3, o, e);
        n_checks++;
        if (o !== e || o.cnt !== 16'h0 || o.lta !== 4'hA || o.ltc !== 4'h3) begin
            n_fail++; $display("FAIL wrap_zero: got %p want %p", o, e);
        end
    endtask

    task automatic test_async_reset();
        resp_t       o, e;
        int          n = 0;
        bit          got = 1'b0;
        logic [61:0] v;
        // Reset landing in the RESP cycle of dut_a.
        use_b = 1'b0;
        model(1'b1, 32'h80, 32'h0BAD_CAFE, 4'hF, 4'h2, 4'h1, 4'h1, e);
        @(negedge clk);
        we = 1'b1; adr = 32'h80; dat_w = 32'h0BAD_CAFE; sel = 4'hF; tgd_w = 4'h2; tga = 4'h1; tgc = 4'h1;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        while (!got && n < 32) begin
            @(negedge clk); n++;
            got = ack_s;
        end
        #1 rst_n = 1'b0;
        #1;
        v = {ack_s, err_s, dat_s, tgd_s, lta_s, ltc_s, cnt_s};
        n_checks++;
        if ({got, v} !== {1'b1, 62'h0}) begin
            n_fail++; $display("FAIL async_reset_resp: got ack_seen=%0b outputs=%h want 1 and 0", got, v);
        end
        cyc = 1'b0; stb = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 32'h80, 32'h0, 4'h0, 4'h0, 4'h2, 4'h2, o, e);
        n_checks++;
        if (o !== e || o.dat !== 32'h0BAD_CAFE || o.cnt !== 16'd1) begin
            n_fail++; $display("FAIL async_reset_readback: got %p want %p", o, e);
        end
        // Reset landing in the WAIT state of dut_b must leave the word untouched.
        use_b = 1'b1;
        xact(1'b1, 32'h84, 32'h55AA_55AA, 4'hF, 4'h4, 4'h0, 4'h0, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL wait_reset_fill: got %p want %p", o, e); end
        @(negedge clk);
        we = 1'b1; adr = 32'h84; dat_w = 32'h0; sel = 4'hF; tgd_w = 4'h0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        model_reset();
        xact(1'b0, 32'h84, 32'h0, 4'h0, 4'h0, 4'h5, 4'h5, o, e);
        n_checks++;
        if (o !== e || o.dat !== 32'h55AA_55AA) begin
            n_fail++; $display("FAIL wait_reset_readback: got %p want %p", o, e);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_byte_lane();
        test_errors();
        test_back_to_back();
        test_abort();
        test_random();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
